// File: rtl/simple_definitions.sv
// Shared definitions for the simple pipeline controller: default widths and the
// controller FSM state encoding.
package simple_definitions;

  localparam int PC_W_DEF   = 8;
  localparam int PC_MAX_DEF = 255;
  localparam int RF_AW_DEF  = 5;
  localparam int RET_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/simple_hazard_unit.sv
// Read-after-write / write-after-write detector: flags an ID instruction whose rs or rd
// collides with the destination of a valid, register-writing instruction in EX or WB.
module simple_hazard_unit
  import simple_definitions::*;
#(
  parameter int RF_AW = RF_AW_DEF
) (
  input  logic             id_valid_i,
  input  logic [RF_AW-1:0] id_rs_addr_i,
  input  logic [RF_AW-1:0] id_rd_addr_i,
  input  logic             ex_valid_i,
  input  logic             ex_writes_rf_i,
  input  logic [RF_AW-1:0] ex_rd_addr_i,
  input  logic             wb_valid_i,
  input  logic             wb_writes_rf_i,
  input  logic [RF_AW-1:0] wb_rd_addr_i,
  output logic             hazard_o
);

  logic ex_hit;
  logic wb_hit;

  assign ex_hit = ex_valid_i && ex_writes_rf_i &&
                  ((id_rs_addr_i == ex_rd_addr_i) || (id_rd_addr_i == ex_rd_addr_i));
  assign wb_hit = wb_valid_i && wb_writes_rf_i &&
                  ((id_rs_addr_i == wb_rd_addr_i) || (id_rd_addr_i == wb_rd_addr_i));

  assign hazard_o = id_valid_i && (ex_hit || wb_hit);

endmodule

// File: rtl/simple_pipe_ctrl.sv
// Sequencer for a 4-stage IF/ID/EX/WB pipeline: issues fetch addresses, tracks stage
// validity and destination registers, stalls on hazards and drains on ALU stop.
module simple_pipe_ctrl
  import simple_definitions::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int PC_MAX = PC_MAX_DEF,
  parameter int RF_AW  = RF_AW_DEF
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start_i,
  input  logic [RF_AW-1:0] id_rs_addr_i,
  input  logic [RF_AW-1:0] id_rd_addr_i,
  input  logic             id_writes_rf_i,
  input  logic             ex_stop_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             id_valid_o,
  output logic             ex_valid_o,
  output logic             wb_valid_o,
  output logic             rf_wen_o,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [RET_W-1:0] retired_o
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PC_MAX);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              id_valid_q, id_valid_d;
  logic              ex_valid_q, ex_valid_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RF_AW-1:0]  ex_rd_q, ex_rd_d;
  logic [RF_AW-1:0]  wb_rd_q, wb_rd_d;
  logic              ex_wr_q, ex_wr_d;
  logic              wb_wr_q, wb_wr_d;
  logic [RET_W-1:0]  retired_q, retired_d;

  logic hazard;
  logic stop;
  logic stall;
  logic fetch;
  logic launch;

  simple_hazard_unit #(.RF_AW(RF_AW)) u_hazard (
    .id_valid_i     (id_valid_q),
    .id_rs_addr_i   (id_rs_addr_i),
    .id_rd_addr_i   (id_rd_addr_i),
    .ex_valid_i     (ex_valid_q),
    .ex_writes_rf_i (ex_wr_q),
    .ex_rd_addr_i   (ex_rd_q),
    .wb_valid_i     (wb_valid_q),
    .wb_writes_rf_i (wb_wr_q),
    .wb_rd_addr_i   (wb_rd_q),
    .hazard_o       (hazard)
  );

  // A stop squashes the ID instruction, so any hazard it carried no longer matters.
  assign stop   = ex_stop_i && ex_valid_q;
  assign stall  = hazard && !stop;
  assign fetch  = (state_q == ST_RUN) && !stall && !stop;
  assign launch = start_i && ((state_q == ST_IDLE) || (state_q == ST_HALT));

  always_comb begin
    id_valid_d = stop ? 1'b0 : (stall ? id_valid_q : fetch);
    ex_valid_d = id_valid_q && !stall && !stop;
    ex_rd_d    = ex_valid_d ? id_rd_addr_i   : ex_rd_q;
    ex_wr_d    = ex_valid_d ? id_writes_rf_i : ex_wr_q;
    wb_valid_d = ex_valid_q;
    wb_rd_d    = ex_rd_q;
    wb_wr_d    = ex_wr_q;

    pc_d = pc_q;
    if (launch) begin
      pc_d = '0;
    end else if (fetch && (pc_q != PC_LAST)) begin
      pc_d = pc_q + PC_W'(1);
    end

    retired_d = retired_q;
    if (launch) begin
      retired_d = '0;
    end else if (wb_valid_q && (retired_q != {RET_W{1'b1}})) begin
      retired_d = retired_q + RET_W'(1);
    end

    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (launch) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop || (fetch && (pc_q == PC_LAST))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!(id_valid_d || ex_valid_d || wb_valid_d)) state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      id_valid_q <= 1'b0;
      ex_valid_q <= 1'b0;
      wb_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      wb_rd_q    <= '0;
      ex_wr_q    <= 1'b0;
      wb_wr_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      ex_valid_q <= ex_valid_d;
      wb_valid_q <= wb_valid_d;
      ex_rd_q    <= ex_rd_d;
      wb_rd_q    <= wb_rd_d;
      ex_wr_q    <= ex_wr_d;
      wb_wr_q    <= wb_wr_d;
      retired_q  <= retired_d;
    end
  end

  assign pc_o       = pc_q;
  assign id_valid_o = id_valid_q;
  assign ex_valid_o = ex_valid_q;
  assign wb_valid_o = wb_valid_q;
  assign rf_wen_o   = wb_valid_q && wb_wr_q;
  assign stall_o    = stall;
  assign busy_o     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o     = (state_q == ST_HALT);
  assign retired_o  = retired_q;

endmodule

// File: tb/tb_simple_pipe_ctrl.sv
// Bench for simple_pipe_ctrl: per-cycle vector tables for each scenario plus a
// retirement scoreboard fed from a shadow instruction pipeline.
module tb_simple_pipe_ctrl;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        start_i;
  logic [4:0]  id_rs_addr_i;
  logic [4:0]  id_rd_addr_i;
  logic        id_writes_rf_i;
  logic        ex_stop_i;
  logic [7:0]  pc_o;
  logic        id_valid_o, ex_valid_o, wb_valid_o;
  logic        rf_wen_o, stall_o, busy_o, done_o;
  logic [15:0] retired_o;

  simple_pipe_ctrl #(.PC_W(8), .PC_MAX(7), .RF_AW(5)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .start_i        (start_i),
    .id_rs_addr_i   (id_rs_addr_i),
    .id_rd_addr_i   (id_rd_addr_i),
    .id_writes_rf_i (id_writes_rf_i),
    .ex_stop_i      (ex_stop_i),
    .pc_o           (pc_o),
    .id_valid_o     (id_valid_o),
    .ex_valid_o     (ex_valid_o),
    .wb_valid_o     (wb_valid_o),
    .rf_wen_o       (rf_wen_o),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .retired_o      (retired_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Instruction memory and the instruction register that holds across stalls.
  logic [4:0] prog_rs [8];
  logic [4:0] prog_rd [8];
  logic [7:0] id_addr, ex_addr, wb_addr;

  always @(posedge clk) begin
    if (!stall_o) id_addr <= pc_o;
    ex_addr <= id_addr;
    wb_addr <= ex_addr;
  end

  assign id_rs_addr_i   = prog_rs[id_addr[2:0]];
  assign id_rd_addr_i   = prog_rd[id_addr[2:0]];
  assign id_writes_rf_i = 1'b1;

  // Scoreboard: addresses expected to retire, in order.
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    if (n_reset && wb_valid_o) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL wb_unexpected: got addr %0d retiring, expected none", wb_addr);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("wb_retire", 64'({wb_addr, rf_wen_o}), 64'({e, 1'b1}));
      end
    end
  end

  typedef struct packed {
    logic        start;
    logic        stop;
    logic [7:0]  pc;
    logic [2:0]  vld;
    logic        stall;
    logic        busy;
    logic        done;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic st, input logic sp, input int pc, input logic [2:0] vld,
                     input logic stl, input logic bsy, input logic dn, input int ret);
    vecs.push_back('{st, sp, 8'(pc), vld, stl, bsy, dn, 16'(ret)});
  endtask

  task automatic set_prog(input bit with_hazard);
    for (int k = 0; k < 8; k++) begin
      prog_rs[k] = 5'(k + 16);
      prog_rd[k] = 5'(k + 8);
    end
    if (with_hazard) begin
      prog_rd[0] = 5'd3;
      prog_rs[1] = 5'd3;
    end
  endtask

  task automatic expect_retire(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(8'(k));
  endtask

  task automatic kick();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_vecs(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      start_i   = vecs[i].start;
      ex_stop_i = vecs[i].stop;
      #1;
      check($sformatf("row%0d", i),
            64'({pc_o, id_valid_o, ex_valid_o, wb_valid_o, stall_o, busy_o, done_o, retired_o}),
            64'({vecs[i].pc, vecs[i].vld, vecs[i].stall, vecs[i].busy, vecs[i].done, vecs[i].ret}));
      @(negedge clk);
    end
    start_i   = 1'b0;
    ex_stop_i = 1'b0;
  endtask

  int b_basic, b_haz, b_stop, b_both;

  initial begin
    // Straight run; stop on row 1 arrives with EX empty and must be ignored.
    b_basic = vecs.size();
    add(0, 0, 0, 3'b000, 0, 1, 0, 0);
    add(0, 1, 1, 3'b100, 0, 1, 0, 0);
    add(0, 0, 2, 3'b110, 0, 1, 0, 0);
    add(0, 0, 3, 3'b111, 0, 1, 0, 0);
    add(0, 0, 4, 3'b111, 0, 1, 0, 1);
    add(0, 0, 5, 3'b111, 0, 1, 0, 2);
    add(0, 0, 6, 3'b111, 0, 1, 0, 3);
    add(0, 0, 7, 3'b111, 0, 1, 0, 4);
    add(0, 0, 7, 3'b111, 0, 1, 0, 5);
    add(0, 0, 7, 3'b011, 0, 1, 0, 6);
    add(0, 0, 7, 3'b001, 0, 1, 0, 7);
    add(0, 0, 7, 3'b000, 0, 0, 1, 8);
    // I0 writes r3, I1 reads r3: two stall cycles; start in RUN ignored.
    b_haz = vecs.size();
    add(0, 0, 0, 3'b000, 0, 1, 0, 0);
    add(0, 0, 1, 3'b100, 0, 1, 0, 0);
    add(0, 0, 2, 3'b110, 1, 1, 0, 0);
    add(0, 0, 2, 3'b101, 1, 1, 0, 0);
    add(0, 0, 2, 3'b100, 0, 1, 0, 1);
    add(0, 0, 3, 3'b110, 0, 1, 0, 1);
    add(1, 0, 4, 3'b111, 0, 1, 0, 1);
    add(0, 0, 5, 3'b111, 0, 1, 0, 2);
    add(0, 0, 6, 3'b111, 0, 1, 0, 3);
    add(0, 0, 7, 3'b111, 0, 1, 0, 4);
    add(0, 0, 7, 3'b111, 0, 1, 0, 5);
    add(0, 0, 7, 3'b011, 0, 1, 0, 6);
    add(0, 0, 7, 3'b001, 0, 1, 0, 7);
    add(0, 0, 7, 3'b000, 0, 0, 1, 8);
    // Stop on address 2 in EX; start in DRAIN ignored.
    b_stop = vecs.size();
    add(0, 0, 0, 3'b000, 0, 1, 0, 0);
    add(0, 0, 1, 3'b100, 0, 1, 0, 0);
    add(0, 0, 2, 3'b110, 0, 1, 0, 0);
    add(0, 0, 3, 3'b111, 0, 1, 0, 0);
    add(0, 1, 4, 3'b111, 0, 1, 0, 1);
    add(1, 0, 4, 3'b001, 0, 1, 0, 2);
    add(0, 0, 4, 3'b000, 0, 0, 1, 3);
    // Stop and hazard in the same cycle.
    b_both = vecs.size();
    add(0, 0, 0, 3'b000, 0, 1, 0, 0);
    add(0, 0, 1, 3'b100, 0, 1, 0, 0);
    add(0, 1, 2, 3'b110, 0, 1, 0, 0);
    add(0, 0, 2, 3'b001, 0, 1, 0, 0);
    add(0, 0, 2, 3'b000, 0, 0, 1, 1);

    set_prog(0);
    n_reset   = 1'b0;
    start_i   = 1'b1;
    ex_stop_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state",
          64'({pc_o, id_valid_o, ex_valid_o, wb_valid_o, rf_wen_o, stall_o, busy_o, done_o, retired_o}),
          64'(0));
    n_reset = 1'b1;
    start_i = 1'b0;
    @(negedge clk);

    expect_retire(8); kick(); run_vecs(b_basic, 12);
    expect_retire(8); kick(); run_vecs(b_basic, 12);
    set_prog(1);
    expect_retire(8); kick(); run_vecs(b_haz, 14);
    set_prog(0);
    expect_retire(3); kick(); run_vecs(b_stop, 7);
    set_prog(1);
    expect_retire(1); kick(); run_vecs(b_both, 5);
    check("sb_drained_runs", 64'(exp_q.size()), 64'(0));

    // Reset mid-RUN at pc 4, with start held high through reset.
    set_prog(0);
    expect_retire(8);
    kick();
    repeat (4) @(negedge clk);
    #1;
    check("pre_reset_pc", 64'(pc_o), 64'(4));
    n_reset = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    #1;
    check("mid_run_reset",
          64'({pc_o, id_valid_o, ex_valid_o, wb_valid_o, rf_wen_o, stall_o, busy_o, done_o, retired_o}),
          64'(0));
    exp_q.delete();
    @(negedge clk);
    n_reset = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    #1;
    check("idle_after_reset", 64'({pc_o, id_valid_o, busy_o, done_o, retired_o}), 64'(0));
    @(negedge clk);
    #1;
    check("still_idle", 64'({busy_o, done_o}), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
